seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for NDIG common-anode 7-segment digits sharing one segment bus.
//  It latches a packed nibble word once per frame, so displayed digits never tear.
//  It scans one digit per slot and decodes it in BCD or hex mode, with per-digit decimal
//  points, leading-zero blanking and an anti-ghost dead time. It sits between the
//  register/MMIO side and the board display pins, and supersedes per-digit static decoders.
// PARAMETERS
//  NDIG      8     number of digits, 1..16
//  SLOT_CYC  1000  clk cycles per digit slot, >= 2*DEAD_CYC+1
//  DEAD_CYC  4     cycles at slot start with all anodes off (ghost suppression), >= 1
//  HEX_EN    1     1: hex_mode honoured; 0: hex_mode ignored, BCD decode only
// PORTS
//  clk        in   1        single clock, all state on posedge
//  rst        in   1        asynchronous, active-high reset
//  en         in   1        display enable; 0 = all anodes off, scan keeps running
//  hex_mode   in   1        1: codes A-F shown as glyphs; 0: codes 10-15 shown blank
//  blank_lz   in   1        1: suppress leading zeros
//  data       in   4*NDIG   digit i = data[4i+3:4i], digit 0 = least significant
//  dp         in   NDIG     decimal point request per digit
//  seg        out  8        seg[7:1] = a..g, seg[0] = dp; all active-low
//  an         out  NDIG     digit select, active-low, at most one bit low
//  frame_done out  1        1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset values
//   - seg = 8'hFF, an = all 1, frame_done = 0.
//   - Slot counter = 0, digit index = 0, shadow data/dp/hex/blank_lz = 0.
//  Slot counter
//   - Counts 0..SLOT_CYC-1 and wraps; at wrap, digit index increments mod NDIG.
//  Frame latch
//   - data, dp, hex_mode and blank_lz are sampled into shadow registers on the cycle
//     the digit index wraps NDIG-1 -> 0, and also on the first cycle after reset release.
//   - Input changes mid-frame do not appear until the next frame.
//  Dead time
//   - While slot counter < DEAD_CYC: an = all 1, seg = 8'hFF.
//  Active part of slot
//   - an[idx] = 0 when en = 1; an = all 1 and seg = FF when en = 0.
//  Decode, table a..g with 0 = lit
//   - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100,
//     5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
//   - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 (hex only).
//   - Codes 10-15 outside hex mode give 1111111.
//   - seg[0] = ~dp_shadow[idx].
//  Leading-zero blanking
//   - Digit i is blank when blank_lz=1, its code is 0, and all more-significant digits
//     are 0 and blank.
//   - Digit 0 is never blanked.
//   - A blanked digit still shows its dp if requested.
//  Registering and latency
//   - seg and an are registered: one cycle of latency from slot/index state to pins.
//   - an and seg always change on the same edge.
//  frame_done
//   - Pulses on the cycle the index wraps NDIG-1 -> 0, coincident with the shadow load.
//  Boundary cases
//   - NDIG=1: the index stays 0 and every slot is a frame.
//   - rst asserted mid-slot: outputs return to reset values immediately (async).
//   - en toggled mid-slot: takes effect on the next registered output and does not
//     restart the slot.
// STRUCTURE
//  Package seg7_pkg
//   - Segment glyph localparams (SEG_0..SEG_F, SEG_BLANK = 7'h7F).
//   - Function seg7_glyph(code, hex) returning 7 bits.
//  Sub-module seg7_glyph_dec
//   - Combinational: 4-bit code + hex enable -> 7-bit a..g.
//   - One instance on the muxed digit.
//  Top level
//   - Slot counter, index counter, shadow registers, leading-zero mask, output registers.
// TESTING
//  T1
//   - Stimulus: NDIG=4, SLOT_CYC=10, DEAD_CYC=2, data=16'h1234, en=1.
//   - Required: over one frame, an cycles 1110, 1101, 1011, 0111.
//   - Required: seg[7:1] = 4, 3, 2, 1 glyphs; an = 1111 for 2 cycles at each slot start.
//  T2
//   - Stimulus: data=16'h00A0, hex_mode=1, then hex_mode=0.
//   - Required: digit 1 shows 0001000 in hex mode.
//   - Required: digit 1 shows 1111111 from the frame after the change.
//  T3
//   - Stimulus: blank_lz=1, data=16'h0070, dp=4'b1000.
//   - Required: digits 3 and 2 are blank; digit 3 has seg[0]=0; digit 1 = 7; digit 0 = 0.
//   - Stimulus: data=16'h0000.
//   - Required: only digit 0 is lit, showing 0.
//  T4
//   - Stimulus: change data from 16'h1111 to 16'h2222 in the middle of slot 2.
//   - Required: slots 2-3 of that frame still show 1; the next frame shows 2.
//   - Required: frame_done pulses exactly once per 4*SLOT_CYC cycles.
//  T5
//   - Stimulus: assert rst asynchronously mid-slot.
//   - Required: seg=FF and an=1111 with no clock edge; scanning restarts at digit 0.
//  T6
//   - Stimulus: en=0 for a whole frame.
//   - Required: an=all 1 throughout; frame_done still pulses; display resumes on the next slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment glyph constants (a..g, 0 = lit) and the code-to-glyph lookup shared by the scan driver.
// Pure combinational helpers; no latency, no flow control.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes 10-15 render blank unless hex is set.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex);
        logic [6:0] g;
        g = SEG_BLANK;
        case (code)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = hex ? SEG_A : SEG_BLANK;
            4'hB: g = hex ? SEG_B : SEG_BLANK;
            4'hC: g = hex ? SEG_C : SEG_BLANK;
            4'hD: g = hex ? SEG_D : SEG_BLANK;
            4'hE: g = hex ? SEG_E : SEG_BLANK;
            4'hF: g = hex ? SEG_F : SEG_BLANK;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational nibble-to-glyph decoder for the currently scanned digit.
// Zero latency; no flow control.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex,
    output logic [6:0] glyph
);

    assign glyph = seg7_glyph(code, hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with per-frame shadow latch, LZ blanking and dead time.
// seg/an are registered (1 cycle after slot state); free-running, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int SLOT_CYC = 1000,
    parameter int DEAD_CYC = 4,
    parameter int HEX_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              hex_mode,
    input  logic              blank_lz,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [NDIG-1:0]  AN_ONE    = NDIG'(1);

    logic [CNT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]     idx;
    logic                 first_cyc;
    logic [NDIG-1:0][3:0] data_sh;
    logic [NDIG-1:0]      dp_sh;
    logic                 hex_sh;
    logic                 blz_sh;
    logic                 slot_end;
    logic                 frame_end;
    logic                 load_sh;
    logic [NDIG-1:0]      lz_mask;
    logic                 lz_run;
    logic [6:0]           glyph;
    logic [7:0]           seg_nxt;
    logic [NDIG-1:0]      an_nxt;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign load_sh    = frame_end || first_cyc;
    assign frame_done = frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            idx       <= '0;
            first_cyc <= 1'b1;
        end else begin
            first_cyc <= 1'b0;
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow copy is only refreshed at frame boundaries so a frame never mixes old and new digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sh <= '0;
            dp_sh   <= '0;
            hex_sh  <= 1'b0;
            blz_sh  <= 1'b0;
        end else if (load_sh) begin
            data_sh <= data;
            dp_sh   <= dp;
            hex_sh  <= hex_mode;
            blz_sh  <= blank_lz;
        end
    end

    // A digit blanks only while every more-significant digit is also a blanked zero.
    always_comb begin
        lz_mask = '0;
        lz_run  = blz_sh;
        for (int i = NDIG - 1; i >= 1; i--) begin
            lz_run     = lz_run && (data_sh[i] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    seg7_glyph_dec u_dec (
        .code  (data_sh[idx]),
        .hex   (hex_sh && (HEX_EN != 0)),
        .glyph (glyph)
    );

    always_comb begin
        seg_nxt = 8'hFF;
        an_nxt  = '1;
        if (en && (slot_cnt >= DEAD_END)) begin
            an_nxt  = ~(AN_ONE << idx);
            seg_nxt = {(lz_mask[idx] ? SEG_BLANK : glyph), ~dp_sh[idx]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NDIG=4, SLOT_CYC=10, DEAD_CYC=2).
// Stimulus pushes expected {an, seg} per displayed slot; the monitor pops at each slot's first lit cycle.
module tb_seg7_scan_driver;

    localparam int NDIG = 4;
    localparam int SLOT = 10;
    localparam int DEAD = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        hex_mode;
    logic        blank_lz;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    seg7_scan_driver #(
        .NDIG     (NDIG),
        .SLOT_CYC (SLOT),
        .DEAD_CYC (DEAD),
        .HEX_EN   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .data       (data),
        .dp         (dp),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] s);
        exp_t e;
        e.an  = a;
        e.seg = s;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        push(4'b1110, s0);
        push(4'b1101, s1);
        push(4'b1011, s2);
        push(4'b0111, s3);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_q(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (q.size() > target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, q.size(), target);
    endtask

    task automatic wait_an(input logic [3:0] value, input int budget, input string name);
        int n;
        n = 0;
        while (an !== value && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, {28'h0, an}, {28'h0, value});
    endtask

    // Monitor: slot contents, in-slot stability, dead-time length, frame_done period and alignment.
    logic in_act, have_prev, fd_seen, fd_d1, fd_d2;
    logic [3:0] an_d1;
    int   run, gap;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            in_act    = 1'b0;
            have_prev = 1'b0;
            fd_seen   = 1'b0;
            fd_d1     = 1'b0;
            fd_d2     = 1'b0;
            an_d1     = 4'hF;
            run       = 0;
            gap       = 0;
        end else begin
            if (fd_d2 && en)
                check("fd_align", {24'h0, an_d1, an}, {24'h0, 4'b0111, 4'hF});
            gap++;
            if (frame_done) begin
                if (fd_seen)
                    check("fd_period", gap, 4 * SLOT);
                fd_seen = 1'b1;
                gap     = 0;
            end
            if (an !== 4'hF) begin
                if (!in_act) begin
                    if (have_prev)
                        check("dead_len", run, DEAD);
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_slot: got an=%b seg=%h, expected no lit digit at %0t",
                                 an, seg, $time);
                        cur.an  = an;
                        cur.seg = seg;
                    end else begin
                        cur = q.pop_front();
                        check("slot", {20'h0, an, seg}, {20'h0, cur.an, cur.seg});
                    end
                    in_act = 1'b1;
                end else begin
                    check("hold", {20'h0, an, seg}, {20'h0, cur.an, cur.seg});
                end
            end else begin
                if (in_act) begin
                    have_prev = 1'b1;
                    run       = 1;
                end else begin
                    run++;
                end
                in_act = 1'b0;
            end
            fd_d2 = fd_d1;
            fd_d1 = frame_done;
            an_d1 = an;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd_cnt;
        rst      = 1'b0;
        en       = 1'b1;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        data     = 16'h0000;
        dp       = 4'h0;
        #1 rst = 1'b1;
        #2;
        check("rst_seg", {24'h0, seg}, 32'h0000_00FF);
        check("rst_an", {28'h0, an}, 32'h0000_000F);
        check("rst_fd", {31'h0, frame_done}, 32'h0);

        // T1: basic scan order and glyphs
        data = 16'h1234;
        apply_reset();
        push_frame(8'h99, 8'h0D, 8'h25, 8'h9F);
        wait_q(0, 200, "t1_drain");

        // T2: hex glyph, then hex off from the following frame
        data     = 16'h00A0;
        hex_mode = 1'b1;
        apply_reset();
        push_frame(8'h03, 8'h11, 8'h03, 8'h03);
        push_frame(8'h03, 8'hFF, 8'h03, 8'h03);
        wait_q(6, 100, "t2_mid");
        hex_mode = 1'b0;
        wait_q(0, 200, "t2_drain");

        // T3: leading-zero blanking with dp on a blanked digit, then all zeros
        data     = 16'h0070;
        dp       = 4'b1000;
        blank_lz = 1'b1;
        apply_reset();
        push_frame(8'h03, 8'h1F, 8'hFF, 8'hFE);
        push_frame(8'h03, 8'hFF, 8'hFF, 8'hFF);
        wait_q(6, 100, "t3_mid");
        data = 16'h0000;
        dp   = 4'b0000;
        wait_q(0, 200, "t3_drain");

        // T4: mid-slot data change is held until the next frame
        data     = 16'h1111;
        blank_lz = 1'b0;
        apply_reset();
        push_frame(8'h9F, 8'h9F, 8'h9F, 8'h9F);
        push_frame(8'h25, 8'h25, 8'h25, 8'h25);
        push_frame(8'h25, 8'h25, 8'h25, 8'h25);
        wait_an(4'b1011, 100, "t4_slot2");
        #2 data = 16'h2222;
        wait_q(0, 300, "t4_drain");

        // T5: asynchronous reset mid-slot, scan restarts at digit 0
        data = 16'h5678;
        apply_reset();
        push(4'b1110, 8'h01);
        push(4'b1101, 8'h1F);
        wait_q(0, 100, "t5_q");
        check("t5_pre", {28'h0, an}, 32'h0000_000D);
        #2 rst = 1'b1;
        #1;
        check("t5_async_seg", {24'h0, seg}, 32'h0000_00FF);
        check("t5_async_an", {28'h0, an}, 32'h0000_000F);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        push_frame(8'h01, 8'h1F, 8'h41, 8'h49);
        wait_q(0, 200, "t5_drain");

        // T6: display disabled for a whole frame, frame_done keeps pulsing
        data = 16'h1234;
        en   = 1'b0;
        apply_reset();
        fd_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            #1;
            check("t6_an_off", {28'h0, an}, 32'h0000_000F);
            if (frame_done)
                fd_cnt++;
        end
        check("t6_fd_count", fd_cnt, 1);
        push_frame(8'h99, 8'h0D, 8'h25, 8'h9F);
        en = 1'b1;
        wait_q(0, 200, "t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
